// File: rtl/pwm_audio_out_pkg.sv
// Shared types and constants for the PWM audio output stage.
package pwm_audio_out_pkg;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } ramp_state_t;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned MID      = 1 << (SAMPLE_W - 1);
  localparam int unsigned RAMP_MAX = (1 << SAMPLE_W) - 1;
  // Width of the signed sample offset (Sample - MID).
  localparam int unsigned OFF_W    = SAMPLE_W + 1;

endpackage

// File: rtl/mute_ramp_ctrl.sv
// Soft-mute ramp controller: moves a gain ceiling between 0 and full scale,
// one saturating step per PWM period, so mute/unmute never clicks.
module mute_ramp_ctrl
  import pwm_audio_out_pkg::*;
#(
  parameter int unsigned DATA_W    = SAMPLE_W,
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              LatchEn,
  input  logic              Enable,
  output logic [DATA_W-1:0] Ramp,
  output logic              Muted
);

  localparam logic [DATA_W:0] MAX_V  = (DATA_W + 1)'(RAMP_MAX);
  localparam logic [DATA_W:0] STEP_V = (DATA_W + 1)'(RAMP_STEP);

  ramp_state_t       state_q, state_d;
  logic [DATA_W-1:0] ramp_q, ramp_d;
  logic              muted_q, muted_d;
  logic [DATA_W:0]   up_sum;
  logic [DATA_W-1:0] ramp_up_sat, ramp_dn_sat;
  logic              go_up, go_dn;

  // Next ramp level and state; everything holds except on the latch edge.
  always_comb begin
    up_sum      = {1'b0, ramp_q} + STEP_V;
    ramp_up_sat = (up_sum >= MAX_V) ? DATA_W'(MAX_V) : up_sum[DATA_W-1:0];
    ramp_dn_sat = ({1'b0, ramp_q} <= STEP_V) ? '0 : ramp_q - STEP_V[DATA_W-1:0];
    go_up       = 1'b0;
    go_dn       = 1'b0;
    state_d     = state_q;
    ramp_d      = ramp_q;
    muted_d     = muted_q;
    if (LatchEn) begin
      case (state_q)
        MUTED:              go_up = Enable;
        RAMP_UP, RAMP_DOWN: begin
          go_up = Enable;
          go_dn = !Enable;
        end
        RUN:                go_dn = !Enable;
        default:            ;
      endcase
      // Direction reversals continue from the current level, so no jump.
      if (go_up) begin
        ramp_d  = ramp_up_sat;
        state_d = (ramp_up_sat == DATA_W'(MAX_V)) ? RUN : RAMP_UP;
      end else if (go_dn) begin
        ramp_d  = ramp_dn_sat;
        state_d = (ramp_dn_sat == '0) ? MUTED : RAMP_DOWN;
      end
      muted_d = (state_d == MUTED);
    end
  end

  // State, ramp level and registered Muted flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= MUTED;
      ramp_q  <= '0;
      muted_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ramp_q  <= ramp_d;
      muted_q <= muted_d;
    end
  end

  assign Ramp  = ramp_q;
  assign Muted = muted_q;

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output stage: once per 2^DATA_W-clock period latches a sample,
// scales it by min(Volume, mute ramp) around midscale and emits PWM.
module pwm_audio_out
  import pwm_audio_out_pkg::*;
#(
  parameter int unsigned DATA_W    = SAMPLE_W,
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Sample,
  input  logic              Enable,
  input  logic [DATA_W-1:0] Volume,
  output logic              PwmOut,
  output logic              SampleTaken,
  output logic              Muted
);

  localparam int unsigned      PROD_W = 2 * OFF_W;
  localparam logic [DATA_W-1:0] MID_V = DATA_W'(MID);

  logic [DATA_W-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]        duty_q, duty_d;
  logic                     pwm_q, pwm_d;
  logic                     taken_q, taken_d;
  logic                     latch_en;
  logic [DATA_W-1:0]        ramp;
  logic [DATA_W-1:0]        gain;
  logic signed [OFF_W-1:0]  off_sample;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] off_scaled;

  mute_ramp_ctrl #(
    .DATA_W    (DATA_W),
    .RAMP_STEP (RAMP_STEP)
  ) u_ramp (
    .Clock   (Clock),
    .Reset   (Reset),
    .LatchEn (latch_en),
    .Enable  (Enable),
    .Ramp    (ramp),
    .Muted   (Muted)
  );

  // Period counter, scaler and PWM comparator next-state logic.
  always_comb begin
    latch_en   = (cnt_q == '1);
    cnt_d      = cnt_q + DATA_W'(1);
    gain       = (Volume < ramp) ? Volume : ramp;
    off_sample = $signed({1'b0, Sample}) - $signed(OFF_W'(MID));
    prod       = PROD_W'(off_sample) * PROD_W'($signed({1'b0, gain}));
    // Arithmetic shift floors toward -inf, so full-scale lands on 0..254.
    off_scaled = prod >>> DATA_W;
    duty_d     = latch_en ? DATA_W'(off_scaled + PROD_W'(MID)) : duty_q;
    pwm_d      = (cnt_q < duty_q);
    taken_d    = latch_en;
  end

  // Counter, duty, PWM bit and sample-taken strobe registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q   <= '0;
      duty_q  <= MID_V;
      pwm_q   <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      taken_q <= taken_d;
    end
  end

  assign PwmOut      = pwm_q;
  assign SampleTaken = taken_q;

endmodule
